// File: rtl/spi_response_transmitter_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_response_transmitter_if
// Brief    : Request, payload-source and shift-out buffer signals of the
//            SPI response transmitter.
// Revision : 1.0
// ============================================================================
interface spi_response_transmitter_if;
  logic        io_Deselect;
  logic        io_SendResponse;
  logic [7:0]  io_R1;
  logic        io_SendBlock;
  logic [11:0] io_DataBlockSize;
  logic [7:0]  io_DataIn;
  logic        io_DataValid;
  logic        io_DataReady;
  logic        io_ByteTaken;
  logic [7:0]  io_OutputBuffer;
  logic        io_Busy;
  logic        io_Underrun;
  logic        io_Done;

  // Requester / payload source / shift-out buffer side
  modport master (
    output io_Deselect, io_SendResponse, io_R1, io_SendBlock, io_DataBlockSize,
    output io_DataIn, io_DataValid, io_ByteTaken,
    input  io_DataReady, io_OutputBuffer, io_Busy, io_Underrun, io_Done
  );

  // Transmitter side
  modport slave (
    input  io_Deselect, io_SendResponse, io_R1, io_SendBlock, io_DataBlockSize,
    input  io_DataIn, io_DataValid, io_ByteTaken,
    output io_DataReady, io_OutputBuffer, io_Busy, io_Underrun, io_Done
  );
endinterface
`default_nettype wire

// File: rtl/spi_response_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : spi_response_transmitter
// Brief    : Card-side SPI response sender: NCR fill, R1, optional data block
//            (token, payload, CRC16-CCITT), byte-paced by the shift-out buffer.
// Revision : 1.0
// ============================================================================
module spi_response_transmitter #(
  parameter int NCR_BYTES = 1,
  parameter int GAP_BYTES = 1,
  parameter int MAX_BLOCK = 2048
) (
  input  wire logic                     clock,
  input  wire logic                     reset,
  spi_response_transmitter_if.slave     bus
);

  localparam int c_cnt_w = $clog2(MAX_BLOCK + 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_NCR    = 3'd1,
    ST_R1     = 3'd2,
    ST_GAP    = 3'd3,
    ST_TOKEN  = 3'd4,
    ST_DATA   = 3'd5,
    ST_CRC_HI = 3'd6,
    ST_CRC_LO = 3'd7
  } state_t;

  state_t               state_q,      state_d;
  logic [7:0]           r1_q,         r1_d;
  logic                 send_block_q, send_block_d;
  logic [c_cnt_w-1:0]   size_cnt_q,   size_cnt_d;
  logic [c_cnt_w-1:0]   fetch_cnt_q,  fetch_cnt_d;
  logic [7:0]           fill_cnt_q,   fill_cnt_d;
  logic [15:0]          crc_q,        crc_d;
  logic [7:0]           pref_data_q,  pref_data_d;
  logic                 pref_valid_q, pref_valid_d;
  logic [7:0]           out_q,        out_d;
  logic                 busy_q,       busy_d;
  logic                 ready_q,      ready_d;
  logic                 underrun_q,   underrun_d;
  logic                 done_q,       done_d;

  logic [c_cnt_w-1:0]   size_eff;

  // One payload byte folded into the CRC, MSB first
  function automatic logic [15:0] crc16_next(input logic [15:0] crc,
                                             input logic [7:0]  data);
    logic [15:0] c;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  always_comb begin
    size_eff = c_cnt_w'(bus.io_DataBlockSize);
    if (bus.io_DataBlockSize == 12'd0) size_eff = c_cnt_w'(512);
  end

  always_comb begin
    state_d      = state_q;
    r1_d         = r1_q;
    send_block_d = send_block_q;
    size_cnt_d   = size_cnt_q;
    fetch_cnt_d  = fetch_cnt_q;
    fill_cnt_d   = fill_cnt_q;
    crc_d        = crc_q;
    pref_data_d  = pref_data_q;
    pref_valid_d = pref_valid_q;
    underrun_d   = 1'b0;
    done_d       = 1'b0;

    if (bus.io_DataValid && ready_q) begin
      pref_data_d  = bus.io_DataIn;
      pref_valid_d = 1'b1;
      fetch_cnt_d  = fetch_cnt_q - 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.io_SendResponse) begin
          state_d      = ST_NCR;
          r1_d         = bus.io_R1;
          send_block_d = bus.io_SendBlock;
          size_cnt_d   = size_eff;
          fetch_cnt_d  = bus.io_SendBlock ? size_eff : '0;
          fill_cnt_d   = 8'(NCR_BYTES);
          crc_d        = 16'h0000;
        end
      end
      ST_NCR: begin
        if (bus.io_ByteTaken) begin
          if (fill_cnt_q <= 8'd1) state_d = ST_R1;
          fill_cnt_d = fill_cnt_q - 8'd1;
        end
      end
      ST_R1: begin
        if (bus.io_ByteTaken) begin
          if (!send_block_q) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else if (GAP_BYTES == 0) begin
            state_d = ST_TOKEN;
          end else begin
            state_d    = ST_GAP;
            fill_cnt_d = 8'(GAP_BYTES);
          end
        end
      end
      ST_GAP: begin
        if (bus.io_ByteTaken) begin
          if (fill_cnt_q <= 8'd1) state_d = ST_TOKEN;
          fill_cnt_d = fill_cnt_q - 8'd1;
        end
      end
      ST_TOKEN: begin
        if (bus.io_ByteTaken) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bus.io_ByteTaken) begin
          // A byte arriving in the same cycle is too late to be shifted out
          if (!pref_valid_q) begin
            state_d    = ST_IDLE;
            underrun_d = 1'b1;
          end else begin
            crc_d        = crc16_next(crc_q, pref_data_q);
            pref_valid_d = 1'b0;
            size_cnt_d   = size_cnt_q - 1'b1;
            if (size_cnt_q == c_cnt_w'(1)) state_d = ST_CRC_HI;
          end
        end
      end
      ST_CRC_HI: begin
        if (bus.io_ByteTaken) state_d = ST_CRC_LO;
      end
      ST_CRC_LO: begin
        if (bus.io_ByteTaken) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (bus.io_Deselect) begin
      state_d    = ST_IDLE;
      underrun_d = 1'b0;
      done_d     = 1'b0;
    end

    // Any return to idle drops whatever the prefetch was still holding
    if (state_d == ST_IDLE) begin
      pref_valid_d = 1'b0;
      fetch_cnt_d  = '0;
      size_cnt_d   = '0;
      fill_cnt_d   = 8'd0;
    end

    busy_d  = (state_d != ST_IDLE);
    ready_d = send_block_d && !pref_valid_d && (fetch_cnt_d != '0) &&
              (state_d inside {ST_NCR, ST_R1, ST_GAP, ST_TOKEN, ST_DATA});

    case (state_d)
      ST_R1:     out_d = r1_d;
      ST_TOKEN:  out_d = 8'hFE;
      ST_DATA:   out_d = pref_valid_d ? pref_data_d : 8'hFF;
      ST_CRC_HI: out_d = crc_d[15:8];
      ST_CRC_LO: out_d = crc_d[7:0];
      default:   out_d = 8'hFF;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      r1_q         <= 8'h00;
      send_block_q <= 1'b0;
      size_cnt_q   <= '0;
      fetch_cnt_q  <= '0;
      fill_cnt_q   <= 8'd0;
      crc_q        <= 16'h0000;
      pref_data_q  <= 8'h00;
      pref_valid_q <= 1'b0;
      out_q        <= 8'hFF;
      busy_q       <= 1'b0;
      ready_q      <= 1'b0;
      underrun_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      r1_q         <= r1_d;
      send_block_q <= send_block_d;
      size_cnt_q   <= size_cnt_d;
      fetch_cnt_q  <= fetch_cnt_d;
      fill_cnt_q   <= fill_cnt_d;
      crc_q        <= crc_d;
      pref_data_q  <= pref_data_d;
      pref_valid_q <= pref_valid_d;
      out_q        <= out_d;
      busy_q       <= busy_d;
      ready_q      <= ready_d;
      underrun_q   <= underrun_d;
      done_q       <= done_d;
    end
  end

  assign bus.io_OutputBuffer = out_q;
  assign bus.io_Busy         = busy_q;
  assign bus.io_DataReady    = ready_q;
  assign bus.io_Underrun     = underrun_q;
  assign bus.io_Done         = done_q;

endmodule
`default_nettype wire
